cluster_soc_evt_bridge: RTL and testbench
=========================================

Name: cluster_soc_evt_bridge

Overview:
Cluster-side, single-clock block directly upstream of the SoC domain's cluster-to-SoC event handshakes: the DMA PE event, DMA PE irq and performance-feedback (pf) valid/ack pairs. It gathers single-cycle event pulses from up to NB_SRC cluster sources per channel. For each channel it keeps a saturating pending count and presents one valid/ack handshake to the SoC domain. No events are lost below saturation, and overflow is flagged sticky.

Parameters:
NB_SRC, 8, event sources per channel (cores/DMA ports); minimum 1
CNT_WIDTH, 4, pending-counter width per channel; CNT_MAX = 2**CNT_WIDTH-1; minimum 2

Ports:
clk_i  in  1  cluster clock
rst_i  in  1  synchronous active-high reset
dma_evt_src_i  in  NB_SRC  DMA PE event pulses, one per source
dma_irq_src_i  in  NB_SRC  DMA PE irq pulses
pf_evt_src_i  in  NB_SRC  perf-feedback event pulses
dma_pe_evt_valid_o  out  1  DMA event pending towards SoC
dma_pe_evt_ack_i  in  1  SoC consumed one DMA event
dma_pe_irq_valid_o  out  1  DMA irq pending
dma_pe_irq_ack_i  in  1  SoC consumed one DMA irq
pf_evt_valid_o  out  1  pf event pending
pf_evt_ack_i  in  1  SoC consumed one pf event
pending_cnt_o  out  3*CNT_WIDTH  pending counts {pf, irq, evt}, status only
ovf_o  out  3  sticky overflow {pf, irq, evt}
ovf_clr_i  in  1  clears all ovf_o bits

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i; reset has priority over all other inputs in the same cycle.
- Reset values: all counters 0, all valid outputs 0, ovf_o = 3'b000.
- Channels: the three channels are identical and fully independent. Each holds cnt[CNT_WIDTH-1:0].
- Arrival count: add = popcount(src_i) for the channel, range 0..NB_SRC. The sum is computed at width CNT_WIDTH + clog2(NB_SRC+1) + 1, so no intermediate wrap.
- Consume: dec = ack_i & valid_o. An ack while valid_o = 0 is ignored and has no effect.
- Next count: next = cnt + add - dec, evaluated in one cycle. A simultaneous arrival and ack are both honoured.
- Saturation: if next > CNT_MAX, then cnt <= CNT_MAX and the channel's ovf bit is set. Events beyond saturation are dropped. An ack in the same cycle is still applied before saturation.
- Valid: valid_o is registered, valid_o = (cnt != 0). Latency from a pulse at edge t to valid_o high is 1 cycle, visible after edge t.
- Ack protocol: the SoC may hold ack high for consecutive cycles. Each cycle with ack & valid consumes exactly one event.
  - When cnt = 1 and ack arrives with no new pulse, valid_o drops the next cycle.
  - When cnt = 1 and ack arrives with add > 0, valid_o stays high.
- Source pulses: inputs are sampled every cycle as levels. A source held high for N cycles counts as N events.
- Overflow flags: ovf_o bits are sticky until ovf_clr_i. If the set and clear conditions coincide in a cycle, set wins.
- pending_cnt_o: equals the registered counters directly, with no extra latency.
- Reset mid-operation: pending events are discarded. Valid outputs are 0 in the cycle after the reset edge, even if ack or src are active in that cycle.
- No combinational path from any input to any output.

Test Plan:
1. Reset then idle: rst_i high for 2 cycles, all inputs 0 -> all valid_o = 0, pending_cnt_o = 0, ovf_o = 0.
2. Single event: dma_evt_src_i = 8'h01 for 1 cycle -> dma_pe_evt_valid_o = 1 the next cycle, count 1. Then pulse dma_pe_evt_ack_i for 1 cycle -> valid = 0 the next cycle, count 0.
3. Burst plus simultaneous ack: pf_evt_src_i = 8'hFF in cycle 0 -> count 8. In cycle 1, src = 8'h03 with pf_evt_ack_i = 1 -> count 9, valid stays 1, ovf 0.
4. Saturation: dma_irq_src_i = 8'hFF for 2 consecutive cycles with CNT_WIDTH = 4 -> count 15, ovf_o[1] = 1. Then 15 cycles of ack drain the count to 0, valid = 0, and ovf_o[1] stays 1 until ovf_clr_i.
5. Spurious ack and clear priority: ack with count 0 -> count stays 0. In one cycle, ovf_clr_i = 1 together with a new overflow -> ovf bit remains 1.
6. Reset mid-drain: count 5 on the evt channel, rst_i asserted together with ack and src = 8'h0F -> count 0 and valid 0 the next cycle. Other channels are also cleared.

Source files
------------

// File: rtl/cluster_soc_evt_bridge.sv
// cluster_soc_evt_bridge
// Collects single-cycle event pulses from NB_SRC cluster sources on three
// independent channels (DMA PE event, DMA PE irq, perf-feedback event),
// keeps a saturating pending count per channel and presents one registered
// valid/ack handshake per channel towards the SoC domain. Channel index
// order everywhere is {pf, irq, evt} = {2, 1, 0}.
module cluster_soc_evt_bridge #(
  parameter int NB_SRC    = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NB_SRC-1:0]      dma_evt_src_i,
  input  logic [NB_SRC-1:0]      dma_irq_src_i,
  input  logic [NB_SRC-1:0]      pf_evt_src_i,
  output logic                   dma_pe_evt_valid_o,
  input  logic                   dma_pe_evt_ack_i,
  output logic                   dma_pe_irq_valid_o,
  input  logic                   dma_pe_irq_ack_i,
  output logic                   pf_evt_valid_o,
  input  logic                   pf_evt_ack_i,
  output logic [3*CNT_WIDTH-1:0] pending_cnt_o,
  output logic [2:0]             ovf_o,
  input  logic                   ovf_clr_i
);

  // Width of a per-cycle arrival count (0..NB_SRC).
  localparam int ADD_W = $clog2(NB_SRC + 1);
  // Width of cnt + add - dec, wide enough that nothing wraps before the
  // saturation check.
  localparam int SUM_W = CNT_WIDTH + ADD_W + 1;
  // Largest value a channel counter can hold.
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Number of set bits in a source vector: the events arriving this cycle.
  function automatic logic [ADD_W-1:0] popcount(input logic [NB_SRC-1:0] vec);
    logic [ADD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      acc = acc + ADD_W'(vec[i]);
    end
    return acc;
  endfunction

  // Source and ack bundles gathered into channel-indexed vectors.
  logic [2:0][NB_SRC-1:0]    w_src;
  logic [2:0]                w_ack;

  // Per-channel next-state terms.
  logic [2:0][ADD_W-1:0]     w_add;
  logic [2:0]                w_dec;
  logic [2:0][SUM_W-1:0]     w_sum;
  logic [2:0][CNT_WIDTH-1:0] w_next;
  logic [2:0]                w_sat;

  // Channel state.
  logic [2:0][CNT_WIDTH-1:0] r_cnt;
  logic [2:0]                r_valid;
  logic [2:0]                r_ovf;

  assign w_src = {pf_evt_src_i, dma_irq_src_i, dma_evt_src_i};
  assign w_ack = {pf_evt_ack_i, dma_pe_irq_ack_i, dma_pe_evt_ack_i};

  // Next count per channel: arrivals minus an honoured ack, then saturate.
  // An ack only counts while valid is high, so the sum can never go below 0,
  // and the ack is applied before the saturation check.
  always_comb begin
    w_add  = '0;
    w_dec  = '0;
    w_sum  = '0;
    w_next = '0;
    w_sat  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_add[ch] = popcount(w_src[ch]);
      w_dec[ch] = w_ack[ch] & r_valid[ch];
      w_sum[ch] = SUM_W'(r_cnt[ch]) + SUM_W'(w_add[ch]) - SUM_W'(w_dec[ch]);
      if (w_sum[ch] > SUM_MAX) begin
        w_next[ch] = CNT_MAX;
        w_sat[ch]  = 1'b1;
      end else begin
        w_next[ch] = w_sum[ch][CNT_WIDTH-1:0];
        w_sat[ch]  = 1'b0;
      end
    end
  end

  // Counter, valid and sticky overflow registers; reset discards everything
  // pending, and an overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_valid <= 3'b000;
      r_ovf   <= 3'b000;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        r_cnt[ch]   <= w_next[ch];
        r_valid[ch] <= (w_next[ch] != '0);
        r_ovf[ch]   <= w_sat[ch] | (r_ovf[ch] & ~ovf_clr_i);
      end
    end
  end

  assign dma_pe_evt_valid_o = r_valid[0];
  assign dma_pe_irq_valid_o = r_valid[1];
  assign pf_evt_valid_o     = r_valid[2];
  assign pending_cnt_o      = r_cnt;
  assign ovf_o              = r_ovf;

endmodule

// File: tb/tb_cluster_soc_evt_bridge.sv
// Directed bench for cluster_soc_evt_bridge with a queue-based scoreboard:
// each driven cycle pushes its hand-computed expected state, and a monitor
// on the falling edge pops and compares it against the DUT outputs.
module tb_cluster_soc_evt_bridge;

  localparam int NB_SRC    = 8;
  localparam int CNT_WIDTH = 4;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] dma_evt_src_i;
  logic [7:0] dma_irq_src_i;
  logic [7:0] pf_evt_src_i;
  logic       dma_pe_evt_valid_o;
  logic       dma_pe_evt_ack_i;
  logic       dma_pe_irq_valid_o;
  logic       dma_pe_irq_ack_i;
  logic       pf_evt_valid_o;
  logic       pf_evt_ack_i;
  logic [11:0] pending_cnt_o;
  logic [2:0] ovf_o;
  logic       ovf_clr_i;

  typedef struct {
    logic [11:0] cnt;
    logic [2:0]  vld;
    logic [2:0]  ovf;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  cluster_soc_evt_bridge #(.NB_SRC(NB_SRC), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .dma_evt_src_i      (dma_evt_src_i),
    .dma_irq_src_i      (dma_irq_src_i),
    .pf_evt_src_i       (pf_evt_src_i),
    .dma_pe_evt_valid_o (dma_pe_evt_valid_o),
    .dma_pe_evt_ack_i   (dma_pe_evt_ack_i),
    .dma_pe_irq_valid_o (dma_pe_irq_valid_o),
    .dma_pe_irq_ack_i   (dma_pe_irq_ack_i),
    .pf_evt_valid_o     (pf_evt_valid_o),
    .pf_evt_ack_i       (pf_evt_ack_i),
    .pending_cnt_o      (pending_cnt_o),
    .ovf_o              (ovf_o),
    .ovf_clr_i          (ovf_clr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Drive one cycle of inputs, let the edge happen, push the expected state.
  task automatic cyc(input string tag,
                     input logic [7:0] e, input logic [7:0] i, input logic [7:0] p,
                     input logic a_e, input logic a_i, input logic a_p,
                     input logic clr, input logic rst,
                     input logic [3:0] x_e, input logic [3:0] x_i, input logic [3:0] x_p,
                     input logic [2:0] x_ovf);
    exp_t x;
    dma_evt_src_i    = e;
    dma_irq_src_i    = i;
    pf_evt_src_i     = p;
    dma_pe_evt_ack_i = a_e;
    dma_pe_irq_ack_i = a_i;
    pf_evt_ack_i     = a_p;
    ovf_clr_i        = clr;
    rst_i            = rst;
    @(posedge clk_i);
    x.cnt = {x_p, x_i, x_e};
    x.vld = {(x_p != 4'd0), (x_i != 4'd0), (x_e != 4'd0)};
    x.ovf = x_ovf;
    x.tag = tag;
    exp_q.push_back(x);
    #1;
  endtask

  // Monitor: compare every registered output against the oldest expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      total++;
      if (pending_cnt_o !== x.cnt) begin
        bad++;
        $display("FAIL %s cnt: got %h want %h", x.tag, pending_cnt_o, x.cnt);
      end
      total++;
      if ({pf_evt_valid_o, dma_pe_irq_valid_o, dma_pe_evt_valid_o} !== x.vld) begin
        bad++;
        $display("FAIL %s valid: got %b want %b", x.tag,
                 {pf_evt_valid_o, dma_pe_irq_valid_o, dma_pe_evt_valid_o}, x.vld);
      end
      total++;
      if (ovf_o !== x.ovf) begin
        bad++;
        $display("FAIL %s ovf: got %b want %b", x.tag, ovf_o, x.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    //   tag          e      i      p      ae    ai    ap    clr   rst   evt   irq   pf    ovf
    // 1. reset then idle
    cyc("rst0",    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000);
    cyc("rst1",    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000);
    cyc("idle",    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
    // 2. single event then ack
    cyc("single",  8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 3'b000);
    cyc("sack",    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
    // 3. burst then arrival together with ack
    cyc("burst",   8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd8, 3'b000);
    cyc("burstak", 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 3'b000);
    // 4. saturation on irq, then drain
    cyc("sat0",    8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 4'd9, 3'b000);
    cyc("sat1",    8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 4'd9, 3'b010);
    for (int k = 1; k <= 15; k++) begin
      cyc("drain", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
          4'd0, 4'(15 - k), 4'd9, 3'b010);
    end
    // 5. spurious ack, clear, set-wins-over-clear, ack before saturation
    cyc("spur",    8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 3'b010);
    cyc("clr",     8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd9, 3'b000);
    cyc("setwin",  8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd15, 3'b100);
    cyc("clr2",    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd15, 3'b000);
    cyc("fullak",  8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 3'b000);
    cyc("fullov",  8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 3'b100);
    // held level and cnt=1 boundary with ack
    cyc("lvl0",    8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd15, 3'b100);
    cyc("lvl1",    8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 4'd15, 3'b100);
    cyc("dn1",     8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd15, 3'b100);
    cyc("one_add", 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd15, 3'b100);
    cyc("one_ack", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 3'b100);
    cyc("ack_0",   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 3'b100);
    // 6. reset mid-drain with ack and sources active
    cyc("five",    8'h1F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd15, 3'b100);
    cyc("midrst",  8'h0F, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000);
    cyc("postrst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
      @(posedge clk_i);
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
